// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchroniser plus a per-key stable-count debouncer.
// Outputs are a clean active-low level and one-cycle press/release pulses, all registered.
`timescale 1ns / 1ps

module key_debounce #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              CLOCK,
    input  logic              RESETn,
    input  logic [N_KEYS-1:0] KEY_IN,
    output logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] PRESS,
    output logic [N_KEYS-1:0] RELEASE
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps.
    localparam int unsigned    CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StUp,
        StFall,
        StDown,
        StRise
    } state_e;

    logic [N_KEYS-1:0] s1_q, s1_d;
    logic [N_KEYS-1:0] s2_q, s2_d;
    logic [N_KEYS-1:0] key_q, key_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    state_e            state_q [N_KEYS];
    state_e            state_d [N_KEYS];
    logic [CntW-1:0]   cnt_q   [N_KEYS];
    logic [CntW-1:0]   cnt_d   [N_KEYS];

    // Synchroniser: only s1 ever samples the asynchronous pins.
    always_comb begin
        s1_d = KEY_IN;
        s2_d = s1_q;
    end

    // Per-key debounce FSM: next state, counter and registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            unique case (state_q[i])
                StUp: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StFall;
                        cnt_d[i]   = CntOne;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                StFall: begin
                    if (s2_q[i]) begin
                        // Glitch shorter than the window: drop it silently.
                        state_d[i] = StUp;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StDown;
                        cnt_d[i]   = '0;
                        key_d[i]   = 1'b0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StDown: begin
                    if (s2_q[i]) begin
                        state_d[i] = StRise;
                        cnt_d[i]   = CntOne;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                StRise: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StDown;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i]   = StUp;
                        cnt_d[i]     = '0;
                        key_d[i]     = 1'b1;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StUp;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // State registers; reset returns every channel to released with no pulses pending.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            s1_q      <= '1;
            s2_q      <= '1;
            key_q     <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= StUp;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign KEY     = key_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random stimulus against a run-length model.
`timescale 1ns / 1ps

module tb_key_debounce;

    localparam int N = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] key_in = '1;
    logic [N-1:0] key, press, rel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLOCK   (clk),
        .RESETn  (rst_n),
        .KEY_IN  (key_in),
        .KEY     (key),
        .PRESS   (press),
        .RELEASE (rel)
    );

    // Reference: inputs reach the filter two edges late; a level is accepted once D
    // consecutive delayed samples disagree with the current debounced level.
    logic [N-1:0] m_d1, m_d2, m_key, m_press, m_rel;
    int           m_run [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1    <= '1;
            m_d2    <= '1;
            m_key   <= '1;
            m_press <= '0;
            m_rel   <= '0;
            for (int i = 0; i < N; i++) m_run[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_press[i] <= 1'b0;
                m_rel[i]   <= 1'b0;
                if (m_d2[i] != m_key[i]) begin
                    if (m_run[i] + 1 == D) begin
                        m_key[i]   <= m_d2[i];
                        m_press[i] <= ~m_d2[i];
                        m_rel[i]   <= m_d2[i];
                        m_run[i]   <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            m_d2 <= m_d1;
            m_d1 <= key_in;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] kin);
        @(negedge clk);
        rst_n  = 1'b0;
        key_in = kin;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        logic [N-1:0] ek, ep;
        @(negedge clk);
        rst_n  = 1'b0;
        key_in = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (key !== 2'b11 || press !== 2'b00 || rel !== 2'b00) begin
                failures++;
                $display("FAIL reset_hold c=%0d key=%b press=%b rel=%b want 11/00/00",
                         c, key, press, rel);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            next_cycle();
            ek = (k >= 5) ? 2'b00 : 2'b11;
            ep = (k == 5) ? 2'b11 : 2'b00;
            checks++;
            if (key !== ek || press !== ep || rel !== 2'b00) begin
                failures++;
                $display("FAIL reset_release k=%0d key=%b press=%b rel=%b want %b/%b/00",
                         k, key, press, rel, ek, ep);
            end
            checks++;
            if (key !== m_key || press !== m_press || rel !== m_rel) begin
                failures++;
                $display("FAIL reset_model k=%0d got %b/%b/%b want %b/%b/%b",
                         k, key, press, rel, m_key, m_press, m_rel);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] ek, ep;
        do_reset(2'b11);
        key_in = 2'b10;
        for (int k = 0; k <= 7; k++) begin
            next_cycle();
            ek = (k >= 5) ? 2'b10 : 2'b11;
            ep = (k == 5) ? 2'b01 : 2'b00;
            checks++;
            if (key !== ek || press !== ep || rel !== 2'b00) begin
                failures++;
                $display("FAIL clean_press k=%0d key=%b press=%b rel=%b want %b/%b/00",
                         k, key, press, rel, ek, ep);
            end
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        do_reset(2'b11);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                key_in[0] = (c < 3) ? 1'b0 : 1'b1;
                next_cycle();
                pulses += $countones(press | rel);
                checks++;
                if (key !== 2'b11 || key !== m_key) begin
                    failures++;
                    $display("FAIL glitch_level r=%0d c=%0d key=%b want 11 (model %b)",
                             r, c, key, m_key);
                end
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch_pulses count=%0d want 0", pulses);
        end
    endtask

    task automatic test_toggle();
        int pulses = 0;
        do_reset(2'b11);
        for (int c = 0; c < 20; c++) begin
            key_in[0] = (c % 2 == 0) ? 1'b0 : 1'b1;
            next_cycle();
            pulses += $countones(press | rel);
        end
        checks++;
        if (key !== 2'b11 || pulses != 0) begin
            failures++;
            $display("FAIL toggle key=%b pulses=%0d want 11 and 0", key, pulses);
        end
    endtask

    task automatic test_bouncing_release();
        logic [4:0]   seq = 5'b01101;
        logic [N-1:0] ek, er;
        int           rels = 0;
        do_reset(2'b11);
        key_in = 2'b10;
        for (int c = 0; c < 8; c++) next_cycle();
        checks++;
        if (key !== 2'b10) begin
            failures++;
            $display("FAIL bounce_setup key=%b want 10", key);
        end
        // Bounce pattern 1,0,1,1,0 (LSB first).
        for (int j = 0; j < 5; j++) begin
            key_in[0] = seq[j];
            next_cycle();
            checks++;
            if (key !== 2'b10 || rel !== 2'b00 || press !== 2'b00) begin
                failures++;
                $display("FAIL bounce_during j=%0d key=%b press=%b rel=%b want 10/00/00",
                         j, key, press, rel);
            end
        end
        key_in[0] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            next_cycle();
            ek = (k >= 5) ? 2'b11 : 2'b10;
            er = (k == 5) ? 2'b01 : 2'b00;
            rels += $countones(rel);
            checks++;
            if (key !== ek || rel !== er || press !== 2'b00) begin
                failures++;
                $display("FAIL bounce_release k=%0d key=%b rel=%b press=%b want %b/%b/00",
                         k, key, rel, press, ek, er);
            end
        end
        checks++;
        if (rels != 1) begin
            failures++;
            $display("FAIL bounce_count releases=%0d want 1", rels);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ek, ep;
        do_reset(2'b11);
        key_in = 2'b10;
        for (int k = 0; k <= 3; k++) next_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (key !== 2'b11 || press !== 2'b00 || rel !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_async key=%b press=%b rel=%b want 11/00/00",
                     key, press, rel);
        end
        #1;
        rst_n = 1'b1;
        for (int r = 0; r <= 7; r++) begin
            next_cycle();
            ek = (r >= 5) ? 2'b10 : 2'b11;
            ep = (r == 5) ? 2'b01 : 2'b00;
            checks++;
            if (key !== ek || press !== ep || rel !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid_repress r=%0d key=%b press=%b rel=%b want %b/%b/00",
                         r, key, press, rel, ek, ep);
            end
        end
    endtask

    task automatic test_independent();
        logic [N-1:0] ek, ep, er;
        do_reset(2'b11);
        key_in[0] = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            if (k == 2) key_in[1] = 1'b0;
            next_cycle();
            ep = {(k == 7), (k == 5)};
            ek = {(k < 7), (k < 5)};
            checks++;
            if (press !== ep || key !== ek || rel !== 2'b00) begin
                failures++;
                $display("FAIL indep_press k=%0d key=%b press=%b rel=%b want %b/%b/00",
                         k, key, press, rel, ek, ep);
            end
        end
        key_in = 2'b11;
        for (int k = 0; k <= 7; k++) begin
            next_cycle();
            er = (k == 5) ? 2'b11 : 2'b00;
            ek = (k >= 5) ? 2'b11 : 2'b00;
            checks++;
            if (rel !== er || key !== ek || press !== 2'b00) begin
                failures++;
                $display("FAIL indep_release k=%0d key=%b press=%b rel=%b want %b/00/%b",
                         k, key, press, rel, ek, er);
            end
        end
    endtask

    task automatic test_random();
        do_reset(2'b11);
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 99) < 12) key_in[b] = ~key_in[b];
            end
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            next_cycle();
            checks++;
            if (key !== m_key || press !== m_press || rel !== m_rel) begin
                failures++;
                $display("FAIL random_model c=%0d got %b/%b/%b want %b/%b/%b",
                         c, key, press, rel, m_key, m_press, m_rel);
            end
            checks++;
            if ((press & rel) !== 2'b00) begin
                failures++;
                $display("FAIL random_exclusive c=%0d press=%b rel=%b want disjoint",
                         c, press, rel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_toggle();
        test_bouncing_release();
        test_reset_mid();
        test_independent();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
